// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, requester IDs and read-latency limits for the memory bus arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;
  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_AUX    = 1'b1;
  localparam int   RD_LAT_MIN = 1;
  localparam int   RD_LAT_MAX = 3;
  localparam int   CNT_W      = 2;
endpackage

// File: rtl/arb_rr_select.sv
// arb_rr_select: two-way round-robin winner pick; on a tie the requester that did not win last time gets the grant
module arb_rr_select
  import mem_arb_pkg::*;
(
  input  logic req_0,
  input  logic req_1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);
  assign grant_valid = req_0 | req_1;
  assign grant_id    = (req_0 & req_1) ? ~last_grant : (req_1 ? REQ_AUX : REQ_CORE);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sequencer sharing one synchronous data memory between the core and an auxiliary master
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_0,
  input  logic          req_1,
  input  logic          we_0,
  input  logic          we_1,
  input  logic [AW-1:0] addr_0,
  input  logic [AW-1:0] addr_1,
  input  logic [DW-1:0] wdata_0,
  input  logic [DW-1:0] wdata_1,
  output logic          ack_0,
  output logic          ack_1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);
  // out-of-range latencies are clamped so the wait counter can never underflow
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN : (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  state_e            state_q, state_d;
  logic              last_q, last_d, owner_q, owner_d, we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant_valid, grant_id;
  arb_rr_select u_sel (
    .req_0       (req_0),
    .req_1       (req_1),
    .last_grant  (last_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (grant_valid) begin
        state_d = ST_ISSUE;
        last_d  = grant_id;
        owner_d = grant_id;
        we_d    = grant_id ? we_1 : we_0;
        addr_d  = grant_id ? addr_1 : addr_0;
        wdata_d = grant_id ? wdata_1 : wdata_0;
      end
      ST_ISSUE: begin
        state_d = we_q ? ST_ACK : ST_WAIT;
        cnt_d   = CNT_W'(LAT);
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          rdata_d = mem_rdata;
          state_d = ST_ACK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= REQ_AUX;
      owner_q <= REQ_CORE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end
  assign ack_0     = (state_q == ST_ACK) && (owner_q == REQ_CORE);
  assign ack_1     = (state_q == ST_ACK) && (owner_q == REQ_AUX);
  assign mem_we    = (state_q == ST_ISSUE) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign busy      = state_q != ST_IDLE;
  assign owner     = owner_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table, directed corner sequences and random traffic against a transaction-timeline model
module tb_mem_bus_arbiter;
  localparam int AW = 16, DW = 16, RD_LAT = 2;
  logic clk = 1'b0, reset_n = 1'b0;
  logic req_0 = 0, req_1 = 0, we_0 = 0, we_1 = 0;
  logic [AW-1:0] addr_0 = '0, addr_1 = '0, mem_addr;
  logic [DW-1:0] wdata_0 = '0, wdata_1 = '0, rdata, mem_wdata, mem_rdata;
  logic ack_0, ack_1, mem_we, busy, owner;
  logic pre_en = 1'b0;
  logic [7:0] pre_a = '0;
  logic [DW-1:0] pre_v = '0;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] pipe [RD_LAT];
  int n_chk = 0, n_fail = 0;
  int m_k, m_L;
  logic m_own, m_we, m_last, m_owner;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rd;
  always #5 clk = ~clk;
  mem_bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
    .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
    .ack_0(ack_0), .ack_1(ack_1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );
  // synchronous memory: data for the address sampled at an edge appears RD_LAT cycles later
  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_v;
    else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    pipe[0] <= mem[mem_addr[7:0]];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  // model: m_k counts cycles since the grant; issue at 1, ack at m_L, then back to idle
  initial forever begin
    @(posedge clk);
    if (pre_en) ref_mem[pre_a] = pre_v;
    if (!reset_n) begin
      m_k = 0; m_L = 2; m_own = 0; m_we = 0; m_last = 1; m_owner = 0; m_addr = '0; m_wd = '0; m_rd = '0;
    end else if (m_k == 0) begin
      if (req_0 || req_1) begin
        m_own = (req_0 && req_1) ? !m_last : req_1;
        m_we = m_own ? we_1 : we_0;
        m_addr = m_own ? addr_1 : addr_0;
        m_wd = m_own ? wdata_1 : wdata_0;
        m_last = m_own; m_owner = m_own; m_k = 1;
        m_L = m_we ? 2 : 2 + RD_LAT;
      end
    end else begin
      if (m_k == 1 && m_we) ref_mem[m_addr[7:0]] = m_wd;
      if (!m_we && m_k == m_L - 1) m_rd = ref_mem[m_addr[7:0]];
      m_k = (m_k == m_L) ? 0 : m_k + 1;
    end
    #1;
    chk("m_busy", 32'(busy), 32'(m_k != 0));
    chk("m_mem_we", 32'(mem_we), 32'(m_k == 1 && m_we));
    chk("m_ack_0", 32'(ack_0), 32'(m_k != 0 && m_k == m_L && !m_own));
    chk("m_ack_1", 32'(ack_1), 32'(m_k != 0 && m_k == m_L && m_own));
    chk("m_owner", 32'(owner), 32'(m_owner));
    chk("m_mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("m_mem_wdata", 32'(mem_wdata), 32'(m_wd));
    chk("m_rdata", 32'(rdata), 32'(m_rd));
  end
  typedef struct packed {
    logic r0, w0; logic [15:0] a0, d0;
    logic r1, w1; logic [15:0] a1, d1;
    logic busy, mwe, k0, k1, own; logic [15:0] maddr, rd;
  } vec_t;
  vec_t tv [9];
  int ack_q [$];
  int n0;
  bit p0, p1;
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic clear_in();
    req_0 = 0; req_1 = 0; we_0 = 0; we_1 = 0; addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
  endtask
  task automatic preload(input logic [7:0] a, input logic [DW-1:0] v);
    pre_a = a; pre_v = v; pre_en = 1; tick(); pre_en = 0;
  endtask
  task automatic do_reset();
    reset_n = 0; clear_in(); tick(); tick(); reset_n = 1;
  endtask
  task automatic wait_ack(input bit id, input int budget);
    int n = 0;
    while (!(id ? ack_1 : ack_0) && n < budget) begin tick(); n++; end
    chk("ack_wait", 32'(id ? ack_1 : ack_0), 32'd1);
  endtask
  initial begin
    tv[0] = '{1,1,16'h0010,16'hBEEF, 0,0,16'h0,16'h0, 0,0,0,0,0,16'h0000,16'h0000};
    tv[1] = '{1,1,16'h0010,16'hBEEF, 0,0,16'h0,16'h0, 1,1,0,0,0,16'h0010,16'h0000};
    tv[2] = '{1,1,16'h0010,16'hBEEF, 0,0,16'h0,16'h0, 1,0,1,0,0,16'h0010,16'h0000};
    tv[3] = '{0,0,16'h0,16'h0, 1,0,16'h0020,16'h0, 0,0,0,0,0,16'h0010,16'h0000};
    tv[4] = '{0,0,16'h0,16'h0, 1,0,16'h0020,16'h0, 1,0,0,0,1,16'h0020,16'h0000};
    tv[5] = '{0,0,16'h0,16'h0, 1,0,16'h0020,16'h0, 1,0,0,0,1,16'h0020,16'h0000};
    tv[6] = '{0,0,16'h0,16'h0, 1,0,16'h0020,16'h0, 1,0,0,0,1,16'h0020,16'h0000};
    tv[7] = '{0,0,16'h0,16'h0, 1,0,16'h0020,16'h0, 1,0,0,1,1,16'h0020,16'h1234};
    tv[8] = '{0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,0,0,0,1,16'h0020,16'h1234};
    reset_n = 0;
    tick();
    for (int i = 0; i < 256; i++) preload(8'(i), 16'($urandom));
    preload(8'h20, 16'h1234);
    preload(8'h40, 16'hAAAA);
    preload(8'h41, 16'h5555);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_owner", 32'(owner), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    reset_n = 1;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].busy));
      chk($sformatf("tv%0d_mem_we", i), 32'(mem_we), 32'(tv[i].mwe));
      chk($sformatf("tv%0d_ack_0", i), 32'(ack_0), 32'(tv[i].k0));
      chk($sformatf("tv%0d_ack_1", i), 32'(ack_1), 32'(tv[i].k1));
      chk($sformatf("tv%0d_owner", i), 32'(owner), 32'(tv[i].own));
      chk($sformatf("tv%0d_mem_addr", i), 32'(mem_addr), 32'(tv[i].maddr));
      chk($sformatf("tv%0d_rdata", i), 32'(rdata), 32'(tv[i].rd));
      req_0 = tv[i].r0; we_0 = tv[i].w0; addr_0 = tv[i].a0; wdata_0 = tv[i].d0;
      req_1 = tv[i].r1; we_1 = tv[i].w1; addr_1 = tv[i].a1; wdata_1 = tv[i].d1;
      tick();
    end
    // both requesters held high: grants must alternate starting with the core
    do_reset();
    req_0 = 1; we_0 = 1; addr_0 = 16'h0050; wdata_0 = 16'h1111;
    req_1 = 1; we_1 = 1; addr_1 = 16'h0051; wdata_1 = 16'h2222;
    for (int c = 0; c < 14; c++) begin
      chk("tie_one_ack", 32'(ack_0 & ack_1), 32'd0);
      if (ack_0) ack_q.push_back(0);
      if (ack_1) ack_q.push_back(1);
      tick();
    end
    chk("tie_ack_count", 32'(ack_q.size()), 32'd4);
    for (int i = 0; i < ack_q.size() && i < 4; i++) chk($sformatf("tie_order%0d", i), 32'(ack_q[i]), 32'(i % 2));
    // read whose request drops during WAIT still completes, and nothing follows
    do_reset();
    req_0 = 1; we_0 = 0; addr_0 = 16'h0030;
    tick(); tick();
    req_0 = 0;
    n0 = 0;
    for (int c = 0; c < 8; c++) begin
      if (ack_0) n0++;
      tick();
    end
    chk("drop_ack_count", 32'(n0), 32'd1);
    chk("drop_idle", 32'(busy), 32'd0);
    // async reset during ISSUE of a write
    do_reset();
    req_1 = 1; we_1 = 1; addr_1 = 16'h0060; wdata_1 = 16'h3333;
    tick();
    chk("ar_issue_we", 32'(mem_we), 32'd1);
    #2 reset_n = 0;
    #1;
    chk("ar_we_drop", 32'(mem_we), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_no_ack", 32'(ack_0 | ack_1), 32'd0);
    @(posedge clk); #1;
    reset_n = 1;
    req_0 = 1; we_0 = 1; addr_0 = 16'h0061; wdata_0 = 16'h4444;
    addr_1 = 16'h0062;
    wait_ack(0, 6);
    chk("ar_tie_aux_quiet", 32'(ack_1), 32'd0);
    clear_in();
    tick(); tick();
    // back-to-back core reads: rdata holds the first word until the second capture
    do_reset();
    req_0 = 1; we_0 = 0; addr_0 = 16'h0040;
    wait_ack(0, 8);
    chk("b2b_first", 32'(rdata), 32'h0000AAAA);
    tick();
    addr_0 = 16'h0041;
    chk("b2b_hold_idle", 32'(rdata), 32'h0000AAAA);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("b2b_hold%0d", c), 32'(rdata), 32'h0000AAAA);
    end
    wait_ack(0, 4);
    chk("b2b_second", 32'(rdata), 32'h00005555);
    req_0 = 0;
    tick(); tick();
    // random traffic; the model checks every cycle
    do_reset();
    p0 = 0; p1 = 0;
    for (int c = 0; c < 3000; c++) begin
      if (ack_0 || !p0) begin
        p0 = (ack_0 ? $urandom_range(1, 0) : $urandom_range(2, 0)) == 0;
        if (p0) begin we_0 = 1'($urandom_range(1, 0)); addr_0 = 16'($urandom); wdata_0 = 16'($urandom); end
      end
      if (ack_1 || !p1) begin
        p1 = (ack_1 ? $urandom_range(1, 0) : $urandom_range(2, 0)) == 0;
        if (p1) begin we_1 = 1'($urandom_range(1, 0)); addr_1 = 16'($urandom); wdata_1 = 16'($urandom); end
      end
      req_0 = p0 && !(busy && owner == 0 && !ack_0 && $urandom_range(3, 0) == 0);
      req_1 = p1 && !(busy && owner == 1 && !ack_1 && $urandom_range(3, 0) == 0);
      tick();
    end
    clear_in();
    for (int c = 0; c < 10; c++) tick();
    for (int i = 0; i < 256; i++) chk($sformatf("mem%0d", i), 32'(mem[i]), 32'(ref_mem[i]));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
